// File: rtl/t_param_bit_walker.sv
// t_param_bit_walker
// Walks every bit of the constant vector PATTERN, one bit per cycle, and
// checks each bit against an independent shift-register copy. After each
// walk the number of ones seen is compared against the elaboration-time
// popcount of PATTERN. The walk is repeated PASSES times per start.
//
// Ports:
//   clk      in   clock, all state changes on posedge
//   rst      in   synchronous reset, active-high
//   start    in   one-cycle run request, sampled only in IDLE
//   busy     out  high while walking/checking
//   bit_out  out  PATTERN[LSB+bit_idx] of the bit just walked (registered)
//   bit_idx  out  index of the bit currently presented, relative to LSB
//   ones_cnt out  ones seen so far in the current pass
//   done     out  one-cycle pulse when the run ends
//   pass     out  sticky run result, valid with done and held afterwards
//   err_idx  out  bit_idx of the first mismatch, WIDTH on a popcount
//                 mismatch, all ones when no error was seen
module t_param_bit_walker #(
  parameter int                   WIDTH   = 1,
  parameter int                   LSB     = 0,
  parameter logic [LSB+WIDTH-1:LSB] PATTERN = {WIDTH{1'b0}},
  parameter int                   PASSES  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         bit_out,
  output logic [$clog2(WIDTH+1)-1:0]   bit_idx,
  output logic [$clog2(WIDTH+1)-1:0]   ones_cnt,
  output logic                         done,
  output logic                         pass,
  output logic [$clog2(WIDTH+1)-1:0]   err_idx
);

  localparam int IW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WALK  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IW-1:0]    IDX_NONE  = {IW{1'b1}};
  localparam logic [IW-1:0]    IDX_LAST  = IW'(WIDTH - 1);
  localparam logic [IW-1:0]    IDX_WIDTH = IW'(WIDTH);
  localparam logic [IW-1:0]    POPCNT    = IW'($countones(PATTERN));
  localparam logic [3:0]       PC_LAST   = 4'(PASSES - 1);
  // Zero-based copy of the pattern used only to seed the shift register.
  localparam logic [WIDTH-1:0] PAT_SEED  = PATTERN;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [3:0]       pc_q, pc_d;
  logic             busy_q, busy_d;
  logic             bit_out_q, bit_out_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic [IW-1:0]    ones_q, ones_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [IW-1:0]    err_q, err_d;
  logic             pat_bit_s;
  logic [IW-1:0]    err_chk_s;

  // Select PATTERN[LSB+bit_idx] with constant-offset bit-selects only, so the
  // select stays legal for a one-bit pattern and any declared low index.
  always_comb begin
    pat_bit_s = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      pat_bit_s = pat_bit_s | (PATTERN[LSB+i] & (bit_idx_q == IW'(i)));
    end
  end

  // Next-state and output-register logic of the walk FSM.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    pc_d      = pc_q;
    busy_d    = busy_q;
    bit_out_d = bit_out_q;
    bit_idx_d = bit_idx_q;
    ones_d    = ones_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_d     = err_q;
    err_chk_s = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_WALK;
          sr_d      = PAT_SEED;
          pc_d      = 4'd0;
          busy_d    = 1'b1;
          bit_idx_d = {IW{1'b0}};
          ones_d    = {IW{1'b0}};
          pass_d    = 1'b0;
          err_d     = IDX_NONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WALK: begin
        bit_out_d = pat_bit_s;
        // Only the first mismatch of a run is recorded.
        if ((pat_bit_s != sr_q[0]) && (err_q == IDX_NONE)) begin
          err_d = bit_idx_q;
        end else begin
          err_d = err_q;
        end
        sr_d   = sr_q >> 1;
        ones_d = ones_q + IW'(pat_bit_s);
        if (bit_idx_q == IDX_LAST) begin
          state_d = S_CHECK;
        end else begin
          state_d   = S_WALK;
          bit_idx_d = bit_idx_q + IW'(1);
        end
      end
      S_CHECK: begin
        if ((ones_q != POPCNT) && (err_q == IDX_NONE)) begin
          err_chk_s = IDX_WIDTH;
        end else begin
          err_chk_s = err_q;
        end
        err_d = err_chk_s;
        if (pc_q < PC_LAST) begin
          state_d   = S_WALK;
          pc_d      = pc_q + 4'd1;
          sr_d      = PAT_SEED;
          bit_idx_d = {IW{1'b0}};
          ones_d    = {IW{1'b0}};
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_chk_s == IDX_NONE);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sr_q      <= PAT_SEED;
      pc_q      <= 4'd0;
      busy_q    <= 1'b0;
      bit_out_q <= 1'b0;
      bit_idx_q <= {IW{1'b0}};
      ones_q    <= {IW{1'b0}};
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= IDX_NONE;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      pc_q      <= pc_d;
      busy_q    <= busy_d;
      bit_out_q <= bit_out_d;
      bit_idx_q <= bit_idx_d;
      ones_q    <= ones_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
    end
  end

  assign busy     = busy_q;
  assign bit_out  = bit_out_q;
  assign bit_idx  = bit_idx_q;
  assign ones_cnt = ones_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_idx  = err_q;

endmodule

// File: doc/t_param_bit_walker.md
Name: t_param_bit_walker

Overview:
Parametrised regression block that walks every bit of a vector parameter and checks it in hardware. Each bit is read by constant-offset bit-select of the parameter and compared against an independent shift-register copy. Covers the 1-bit-parameter-as-vector case (WIDTH=1) and generalises to any width, a non-zero LSB, and multiple passes. It is instantiated under the test top module `t`, which prints "*-* All Finished *-*" and calls $finish on pass, or calls $stop on fail.

Parameters:
WIDTH, 1, bit width of PATTERN; legal range 1..64.
LSB, 0, declared low index of PATTERN, which is declared [LSB+WIDTH-1:LSB]; legal range 0..7.
PATTERN, {WIDTH{1'b0}}, constant vector under test.
PASSES, 1, number of full walks per start; legal range 1..15.

Ports:
clk  input  1  clock; all state changes on posedge.
rst  input  1  synchronous reset, active-high.
start  input  1  one-cycle request; sampled only in IDLE.
busy  output  1  high from the cycle after an accepted start until DONE is entered.
bit_out  output  1  PATTERN[LSB+bit_idx], registered.
bit_idx  output  $clog2(WIDTH+1)  index of the bit currently presented, relative to LSB.
ones_cnt  output  $clog2(WIDTH+1)  count of ones seen in the current pass.
done  output  1  one-cycle pulse when the run ends.
pass  output  1  sticky; valid while done is high and held afterwards.
err_idx  output  $clog2(WIDTH+1)  bit_idx of the first mismatch; all ones if none.

Behaviour:
- Reset: when rst is high at a posedge, the block enters IDLE.
  - busy=0, bit_out=0, bit_idx=0, ones_cnt=0, done=0, pass=0, err_idx=all ones.
  - Shift register sr is loaded with PATTERN; pass counter pc=0.
  - rst overrides every other input in any state, including mid-walk.
- States: IDLE, WALK, CHECK, DONE.
- IDLE:
  - start=1 -> WALK next cycle; sr reloaded with PATTERN, bit_idx=0, ones_cnt=0, pass cleared.
  - start=0 -> stay in IDLE.
- WALK, one bit per cycle:
  - bit_out <= PATTERN[LSB+bit_idx]; the index is a constant-offset select and must be legal when WIDTH=1.
  - Mismatch when PATTERN[LSB+bit_idx] != sr[0]. On the first mismatch of the run, err_idx <= bit_idx.
  - sr shifts right by one; the vacated MSB is filled with 0.
  - ones_cnt increments by bit_out's new value.
  - When bit_idx==WIDTH-1, go to CHECK; otherwise bit_idx increments.
- CHECK, one cycle:
  - ones_cnt must equal the popcount of PATTERN, computed as an elaboration-time constant.
  - A popcount mismatch with no earlier bit error sets err_idx=WIDTH.
  - If pc<PASSES-1: pc increments, sr is reloaded, bit_idx=0, ones_cnt=0, next state WALK.
  - Otherwise: next state DONE.
- DONE:
  - done=1 for exactly one cycle; pass=1 iff err_idx is all ones.
  - busy falls in the same cycle done rises.
  - Next state IDLE.
- Latency from the start cycle to the done pulse is exactly PASSES*(WIDTH+1)+1 cycles.
- start while busy is ignored.
- start in the same cycle done is high is ignored (the block is in DONE, not IDLE).
- Widths:
  - Counters are sized so bit_idx==WIDTH is representable.
  - No wrap occurs for any legal parameter set.
- WIDTH=1 degenerate case:
  - Each pass is one WALK cycle plus one CHECK cycle.
  - bit_idx stays 0 throughout.
  - sr[0] and PATTERN[LSB] are the sole compare.

Test Plan:
1. WIDTH=1, PATTERN=1'b0, PASSES=1: start at cycle 2 -> done at cycle 5, pass=1, ones_cnt=0, err_idx=1'b1.
2. WIDTH=8, PATTERN=8'hA5, LSB=0: start -> bit_out sequence 1,0,1,0,0,1,0,1; ones_cnt=4; done 10 cycles after start; pass=1.
3. WIDTH=5, LSB=3, PATTERN=5'b10011: bit_out sequence 1,1,0,0,1; ones_cnt=3; pass=1, which confirms the offset select.
4. WIDTH=4, PATTERN=4'hF, PASSES=3: done 16 cycles after start; busy high 15 cycles; ones_cnt=4 at the end of each pass; pass=1.
5. WIDTH=8, PATTERN=8'h3C: rst pulsed at walk cycle 4 -> next cycle IDLE, all outputs at reset values. A new start then completes with pass=1.
6. Start held high across a whole run, plus a start pulse in the done cycle: exactly one run executes, then a second run starts only from the next IDLE sample.
